// File: rtl/wb_arbiter2_if.sv
// Pipelined Wishbone bus bundle (with stall) shared by the arbiter's master and slave ports.
// dat_o carries master-to-slave data; dat_i carries slave-to-master data.
interface if_wb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0]   adr;
  logic [DWIDTH/8-1:0] sel;
  logic                we;
  logic                cyc;
  logic                stb;
  logic [DWIDTH-1:0]   dat_o;
  logic [DWIDTH-1:0]   dat_i;
  logic                ack;
  logic                stall;

  modport master (output adr, sel, we, cyc, stb, dat_o, input dat_i, ack, stall);
  modport slave  (input adr, sel, we, cyc, stb, dat_o, output dat_i, ack, stall);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter; grant held for the whole cyc burst.
// Define WB_ARB_ROUNDROBIN_EN for round-robin contention, otherwise m0 has fixed priority.
module wb_arbiter2 #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int MAXOUT = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  if_wb.slave        m0,
  if_wb.slave        m1,
  if_wb.master       s,
  output logic [1:0] owner_o
);
  localparam int CW = $clog2(MAXOUT + 1);

  // state | meaning
  // IDLE  | no grant, slave bus quiet, both masters stalled
  // G0    | m0 owns the slave bus
  // G1    | m1 owns the slave bus
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  logic [1:0]          owner, owner_nxt, grant;
  logic [CW-1:0]       outst;
  logic                full, inc, dec;
  logic [AWIDTH-1:0]   mux_adr;
  logic [DWIDTH/8-1:0] mux_sel;
  logic [DWIDTH-1:0]   mux_dat;
  logic                mux_we, mux_cyc, mux_stb, stb_out;

  assign full = (outst == CW'(MAXOUT));

  always_comb begin
    mux_adr = '0;
    mux_sel = '0;
    mux_dat = '0;
    mux_we  = 1'b0;
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    case (owner)
      G0: begin
        mux_adr = m0.adr;
        mux_sel = m0.sel;
        mux_dat = m0.dat_o;
        mux_we  = m0.we;
        mux_cyc = m0.cyc;
        mux_stb = m0.stb;
      end
      G1: begin
        mux_adr = m1.adr;
        mux_sel = m1.sel;
        mux_dat = m1.dat_o;
        mux_we  = m1.we;
        mux_cyc = m1.cyc;
        mux_stb = m1.stb;
      end
      default: ;
    endcase
  end

  assign stb_out = mux_stb & ~full;
  assign s.adr   = mux_adr;
  assign s.sel   = mux_sel;
  assign s.dat_o = mux_dat;
  assign s.we    = mux_we;
  assign s.cyc   = mux_cyc;
  assign s.stb   = stb_out;

  assign m0.stall = (owner == G0) ? (s.stall | full) : 1'b1;
  assign m1.stall = (owner == G1) ? (s.stall | full) : 1'b1;
  assign m0.ack   = (owner == G0) & s.ack;
  assign m1.ack   = (owner == G1) & s.ack;
  assign m0.dat_i = s.dat_i;
  assign m1.dat_i = s.dat_i;
  assign owner_o  = owner;

`ifdef WB_ARB_ROUNDROBIN_EN
  // last: 0 = m0 was granted most recently, 1 = m1
  logic last;

  always_comb begin
    if (m0.cyc && m1.cyc) grant = last ? G0 : G1;
    else                  grant = m0.cyc ? G0 : G1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                last <= 1'b1;
    else if (owner == IDLE && owner_nxt != IDLE) last <= (owner_nxt == G1);
  end
`else
  always_comb grant = m0.cyc ? G0 : G1;
`endif

  always_comb begin
    owner_nxt = owner;
    case (owner)
      IDLE:    if (m0.cyc || m1.cyc) owner_nxt = grant;
      G0:      if (!m0.cyc) owner_nxt = IDLE;
      G1:      if (!m1.cyc) owner_nxt = IDLE;
      default: owner_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) owner <= IDLE;
    else          owner <= owner_nxt;
  end

  // An ack with nothing outstanding is not counted; leaving a grant drops any late acks.
  assign inc = stb_out & ~s.stall;
  assign dec = s.ack & (outst != '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                outst <= '0;
    else if (owner_nxt == IDLE)  outst <= '0;
    else if (inc && !dec)        outst <= outst + 1'b1;
    else if (dec && !inc)        outst <= outst - 1'b1;
  end
endmodule
